// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and width helpers for stream_fifo
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DEPTH      = 8;

  // Counter must hold DEPTH itself, not just DEPTH-1
  function automatic int usage_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// rtl/fifo_wrap_ptr.sv - modulo-DEPTH pointer with increment and clear
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PW    = ptr_width(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [PW-1:0] o_ptr
);

  logic [PW-1:0] r_ptr;

  // Explicit wrap so non-power-of-two depths never index past the array
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - valid/ready stream FIFO with optional fall-through and threshold flags
module stream_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int DEPTH           = DEFAULT_DEPTH,
  parameter int FALL_THROUGH    = 0,
  parameter int ALMOST_FULL_TH  = DEPTH - 1,
  parameter int ALMOST_EMPTY_TH = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic [DATA_WIDTH-1:0]         in_data_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [usage_width(DEPTH)-1:0] usage_o,
  output logic                          almost_full_o,
  output logic                          almost_empty_o
);

  localparam int UW = usage_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  if (DEPTH < 1) begin : g_bad_depth
    $fatal(1, "stream_fifo: DEPTH must be >= 1");
  end
  if (ALMOST_FULL_TH > DEPTH) begin : g_bad_af
    $fatal(1, "stream_fifo: ALMOST_FULL_TH exceeds DEPTH");
  end
  if (ALMOST_EMPTY_TH > DEPTH) begin : g_bad_ae
    $fatal(1, "stream_fifo: ALMOST_EMPTY_TH exceeds DEPTH");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [UW-1:0]         r_usage;
  logic [PW-1:0]         w_wr_ptr;
  logic [PW-1:0]         w_rd_ptr;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_bypass;
  logic                  w_wr_en;
  logic                  w_rd_en;

  assign w_empty = (r_usage == '0);
  assign w_full  = (r_usage == UW'(DEPTH));

  // in_ready_o depends only on registered usage and flush, never on out_ready_i
  assign in_ready_o  = !w_full && !flush_i;
  assign out_valid_o = (!w_empty || ((FALL_THROUGH != 0) && in_valid_i)) && !flush_i;

  assign w_push = in_valid_i && in_ready_o;
  assign w_pop  = out_valid_o && out_ready_i;

  // A word handed straight through while empty never touches storage
  assign w_bypass = (FALL_THROUGH != 0) && w_empty && w_push && w_pop;
  assign w_wr_en  = w_push && !w_bypass;
  assign w_rd_en  = w_pop && !w_bypass;

  fifo_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_clr (flush_i),
    .i_inc (w_wr_en),
    .o_ptr (w_wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_clr (flush_i),
    .i_inc (w_rd_en),
    .o_ptr (w_rd_ptr)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_usage <= '0;
    end else begin
      case ({w_wr_en, w_rd_en})
        2'b10:   r_usage <= r_usage + 1'b1;
        2'b01:   r_usage <= r_usage - 1'b1;
        default: r_usage <= r_usage;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[w_wr_ptr] <= in_data_i;
    end
  end

  always_comb begin
    out_data_o = '0;
    if (out_valid_o) begin
      out_data_o = w_empty ? in_data_i : r_mem[w_rd_ptr];
    end
  end

  assign usage_o        = r_usage;
  assign almost_full_o  = (r_usage >= UW'(ALMOST_FULL_TH));
  assign almost_empty_o = (r_usage <= UW'(ALMOST_EMPTY_TH));

endmodule

// File: tb/tb_stream_fifo.sv
// tb/tb_stream_fifo.sv - directed bench for stream_fifo, DEPTH=5 with and without fall-through
module tb_stream_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;

  logic       o0_ready, o0_valid, o0_af, o0_ae;
  logic [7:0] o0_data;
  logic [2:0] o0_usage;
  logic       o1_ready, o1_valid, o1_af, o1_ae;
  logic [7:0] o1_data;
  logic [2:0] o1_usage;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_fifo #(.DATA_WIDTH(8), .DEPTH(5), .FALL_THROUGH(0)) u_ft0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(o0_ready),
    .out_data_o(o0_data), .out_valid_o(o0_valid), .out_ready_i(out_ready),
    .usage_o(o0_usage), .almost_full_o(o0_af), .almost_empty_o(o0_ae)
  );

  stream_fifo #(.DATA_WIDTH(8), .DEPTH(5), .FALL_THROUGH(1)) u_ft1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(o1_ready),
    .out_data_o(o1_data), .out_valid_o(o1_valid), .out_ready_i(out_ready),
    .usage_o(o1_usage), .almost_full_o(o1_af), .almost_empty_o(o1_ae)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    checks++; if (o0_usage !== 3'd0) begin errors++; $display("FAIL reset_usage0 got %0d exp 0", o0_usage); end
    checks++; if (o0_ready !== 1'b1) begin errors++; $display("FAIL reset_ready0 got %b exp 1", o0_ready); end
    checks++; if (o0_valid !== 1'b0) begin errors++; $display("FAIL reset_valid0 got %b exp 0", o0_valid); end
    checks++; if (o0_data !== 8'h00) begin errors++; $display("FAIL reset_data0 got %h exp 00", o0_data); end
    checks++; if (o0_ae !== 1'b1) begin errors++; $display("FAIL reset_ae0 got %b exp 1", o0_ae); end
    checks++; if (o0_af !== 1'b0) begin errors++; $display("FAIL reset_af0 got %b exp 0", o0_af); end
    checks++; if (o1_usage !== 3'd0) begin errors++; $display("FAIL reset_usage1 got %0d exp 0", o1_usage); end
    checks++; if (o1_valid !== 1'b0) begin errors++; $display("FAIL reset_valid1 got %b exp 0", o1_valid); end
    checks++; if (o1_ready !== 1'b1) begin errors++; $display("FAIL reset_ready1 got %b exp 1", o1_ready); end
  endtask

  // Leaves both FIFOs full with 11..15
  task automatic test_fill;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h11 + 8'(i);
      #1;
      checks++; if (o0_usage !== 3'(i)) begin errors++; $display("FAIL fill_usage[%0d] got %0d exp %0d", i, o0_usage, i); end
      checks++; if (o0_ae !== (i <= 1)) begin errors++; $display("FAIL fill_ae[%0d] got %b exp %b", i, o0_ae, (i <= 1)); end
      checks++; if (o0_af !== (i >= 4)) begin errors++; $display("FAIL fill_af[%0d] got %b exp %b", i, o0_af, (i >= 4)); end
      checks++; if (o0_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d] got %b exp 1", i, o0_ready); end
      step();
    end
    in_data = 8'h16;
    #1;
    checks++; if (o0_usage !== 3'd5) begin errors++; $display("FAIL full_usage got %0d exp 5", o0_usage); end
    checks++; if (o0_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", o0_ready); end
    checks++; if (o0_af !== 1'b1) begin errors++; $display("FAIL full_af got %b exp 1", o0_af); end
    checks++; if (o0_data !== 8'h11) begin errors++; $display("FAIL full_head got %h exp 11", o0_data); end
    step();
    checks++; if (o0_usage !== 3'd5) begin errors++; $display("FAIL full_refused0 got %0d exp 5", o0_usage); end
    checks++; if (o1_usage !== 3'd5) begin errors++; $display("FAIL full_refused1 got %0d exp 5", o1_usage); end
    checks++; if (o0_data !== 8'h11) begin errors++; $display("FAIL full_head_kept got %h exp 11", o0_data); end
  endtask

  task automatic test_wrap;
    logic [7:0] q[$];
    int         cnt;
    logic       exp_push;
    q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    cnt = 5;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      in_data = 8'h20 + 8'(k);
      #1;
      exp_push = (cnt != 5);
      checks++; if (o0_ready !== exp_push) begin errors++; $display("FAIL wrap_ready[%0d] got %b exp %b", k, o0_ready, exp_push); end
      checks++; if (o0_valid !== 1'b1 || o0_data !== q[0]) begin errors++; $display("FAIL wrap_data0[%0d] got %h exp %h", k, o0_data, q[0]); end
      checks++; if (o1_data !== q[0]) begin errors++; $display("FAIL wrap_data1[%0d] got %h exp %h", k, o1_data, q[0]); end
      step();
      void'(q.pop_front());
      if (exp_push) q.push_back(in_data); else cnt--;
    end
    in_valid = 1'b0;
    checks++; if (o0_usage !== 3'd4) begin errors++; $display("FAIL wrap_usage got %0d exp 4", o0_usage); end
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (o0_valid !== 1'b1 || o0_data !== q[0]) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", k, o0_data, q[0]); end
      step();
      void'(q.pop_front());
    end
    out_ready = 1'b0;
    #1;
    checks++; if (o0_usage !== 3'd0 || o0_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got usage %0d valid %b exp 0 0", o0_usage, o0_valid); end
  endtask

  task automatic test_fall_through;
    do_reset();
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    #1;
    checks++; if (o1_valid !== 1'b1 || o1_data !== 8'hA5) begin errors++; $display("FAIL ft_bypass got valid %b data %h exp 1 a5", o1_valid, o1_data); end
    checks++; if (o0_valid !== 1'b0 || o0_data !== 8'h00) begin errors++; $display("FAIL ft0_no_bypass got valid %b data %h exp 0 00", o0_valid, o0_data); end
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (o1_usage !== 3'd0) begin errors++; $display("FAIL ft_usage got %0d exp 0", o1_usage); end
    checks++; if (o1_valid !== 1'b0) begin errors++; $display("FAIL ft_valid_after got %b exp 0", o1_valid); end
    checks++; if (o0_usage !== 3'd1 || o0_data !== 8'hA5) begin errors++; $display("FAIL ft0_stored got usage %0d data %h exp 1 a5", o0_usage, o0_data); end
  endtask

  task automatic test_latency;
    do_reset();
    in_valid = 1'b1; in_data = 8'h3C;
    #1;
    checks++; if (o0_valid !== 1'b0) begin errors++; $display("FAIL lat_before got %b exp 0", o0_valid); end
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (o0_valid !== 1'b1 || o0_data !== 8'h3C) begin errors++; $display("FAIL lat_after got valid %b data %h exp 1 3c", o0_valid, o0_data); end
    checks++; if (o1_valid !== 1'b1 || o1_data !== 8'h3C) begin errors++; $display("FAIL lat_ft1_stored got valid %b data %h exp 1 3c", o1_valid, o1_data); end
  endtask

  task automatic test_flush;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'h40 + 8'(i);
      step();
    end
    in_data = 8'h77; flush = 1'b1;
    #1;
    checks++; if (o0_usage !== 3'd3) begin errors++; $display("FAIL flush_pre_usage got %0d exp 3", o0_usage); end
    checks++; if (o0_ready !== 1'b0 || o0_valid !== 1'b0) begin errors++; $display("FAIL flush_hs got ready %b valid %b exp 0 0", o0_ready, o0_valid); end
    checks++; if (o1_valid !== 1'b0) begin errors++; $display("FAIL flush_ft1_valid got %b exp 0", o1_valid); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (o0_usage !== 3'd0 || o0_valid !== 1'b0) begin errors++; $display("FAIL flush_empty0 got usage %0d valid %b exp 0 0", o0_usage, o0_valid); end
    checks++; if (o1_usage !== 3'd0) begin errors++; $display("FAIL flush_empty1 got %0d exp 0", o1_usage); end
    in_valid = 1'b1; in_data = 8'h88;
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (o0_usage !== 3'd1 || o0_data !== 8'h88) begin errors++; $display("FAIL flush_restart got usage %0d data %h exp 1 88", o0_usage, o0_data); end
  endtask

  task automatic test_reset_priority;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'h50 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (o0_usage !== 3'd4 || o0_af !== 1'b1 || o0_ae !== 1'b0) begin errors++; $display("FAIL rp_pre got usage %0d af %b ae %b exp 4 1 0", o0_usage, o0_af, o0_ae); end
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (o0_usage !== 3'd0) begin errors++; $display("FAIL rp_usage got %0d exp 0", o0_usage); end
    checks++; if (o0_ready !== 1'b1) begin errors++; $display("FAIL rp_ready got %b exp 1", o0_ready); end
    checks++; if (o0_ae !== 1'b1 || o0_af !== 1'b0) begin errors++; $display("FAIL rp_flags got ae %b af %b exp 1 0", o0_ae, o0_af); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_wrap();
    test_fall_through();
    test_latency();
    test_flush();
    test_reset_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
